hit_detector: RTL and testbench

HIT_DETECTOR -- requirements
Module: hit_detector

---
 rtl/whack_pkg.sv | 13 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/hit_detector.sv | 112 +++++++++++
 tb/tb_hit_detector.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole hit detector.
package whack_pkg;

  localparam int N_HOLES_DEFAULT = 9;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOCK  = 2'd2
  } hit_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, saturating debounce counter and press (rising edge) detect.
// press is high for the single cycle in which the debounced level has just become 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th differing cycle; the counter never passes CNT_LAST.
        db_q    <= ~db_q;
        cnt_q   <= '0;
        press_q <= ~db_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/hit_detector.sv
// Judges debounced button presses against raised moles and pulses score/miss triggers.
// Optional miss reporting is enabled by defining HIT_DETECTOR_MISS_PENALTY_EN.
//
// state | meaning
// IDLE  | game not running, no pulses, debouncers still active
// ARMED | waiting for a press to judge
// LOCK  | hit scored, presses ignored until the locked mole drops
module hit_detector
  import whack_pkg::*;
#(
  parameter int N_HOLES         = N_HOLES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_HOLES-1:0] btn,
  input  logic [N_HOLES-1:0] mole_mask,
  output logic               score_trigger,
  output logic [IDX_W-1:0]   hit_index,
  output logic               miss_trigger
);

  logic [N_HOLES-1:0] press;
  logic               press_any;
  logic [IDX_W-1:0]   press_idx;

  hit_state_e         state_q, state_d;
  logic               score_q, score_d;
  logic               miss_q, miss_d;
  logic [IDX_W-1:0]   hit_index_q, hit_index_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  for (genvar g = 0; g < N_HOLES; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[g]),
      .press(press[g])
    );
  end

  // Lowest index wins; the other simultaneous presses are simply dropped.
  always_comb begin
    press_any = 1'b0;
    press_idx = '0;
    for (int i = N_HOLES - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_any = 1'b1;
        press_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_q     <= 1'b0;
      miss_q      <= 1'b0;
      hit_index_q <= '0;
      lock_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      hit_index_q <= hit_index_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    score_d     = 1'b0;
    miss_d      = 1'b0;
    hit_index_d = hit_index_q;
    lock_idx_d  = lock_idx_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (press_any) begin
            if (mole_mask[press_idx]) begin
              score_d     = 1'b1;
              hit_index_d = press_idx;
              lock_idx_d  = press_idx;
              state_d     = LOCK;
            end
`ifdef HIT_DETECTOR_MISS_PENALTY_EN
            else begin
              miss_d      = 1'b1;
              hit_index_d = press_idx;
            end
`endif
          end
        end
        LOCK: begin
          if (!mole_mask[lock_idx_q]) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign score_trigger = score_q;
  assign miss_trigger  = miss_q;
  assign hit_index     = hit_index_q;

endmodule

// File: tb/tb_hit_detector.sv
// Self-checking bench for hit_detector: directed scenarios plus random stimulus vs a behavioural model.
module tb_hit_detector;
  import whack_pkg::*;

  localparam int N = 9;
  localparam int D = 4;
`ifdef HIT_DETECTOR_MISS_PENALTY_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] btn;
  logic [N-1:0] mole_mask;
  logic         score_trigger;
  logic         miss_trigger;
  logic [3:0]   hit_index;

  always #5 clk = ~clk;

  hit_detector #(
    .N_HOLES(N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .btn          (btn),
    .mole_mask    (mole_mask),
    .score_trigger(score_trigger),
    .hit_index    (hit_index),
    .miss_trigger (miss_trigger)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: button sample history, debounced levels, game mode.
  logic [N-1:0] bh   [2] = '{default: '0};
  logic [N-1:0] seen [D] = '{default: '0};
  logic [N-1:0] m_db = '0;
  logic [N-1:0] m_press = '0;
  int m_mode = 0;
  int m_lock = 0;
  int m_idx = 0;
  bit m_score = 0;
  bit m_miss = 0;
  int n_score = 0;
  int n_miss = 0;
  int last_idx = 0;

  task automatic model_edge();
    logic [N-1:0] rose;
    int k;
    bit all_diff;
    if (rst) begin
      bh = '{default: '0};
      seen = '{default: '0};
      m_db = '0; m_press = '0;
      m_mode = 0; m_lock = 0; m_idx = 0;
      m_score = 0; m_miss = 0;
    end else begin
      m_score = 0;
      m_miss = 0;
      if (!enable) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (m_press != '0) begin
          k = 0;
          while (!m_press[k]) k++;
          if (mole_mask[k]) begin
            m_score = 1; m_idx = k; m_lock = k; m_mode = 2;
          end else if (MISS_EN) begin
            m_miss = 1; m_idx = k;
          end
        end
      end else if (!mole_mask[m_lock]) m_mode = 1;
      // the debouncer sees the button as it was two edges ago
      for (int j = D - 1; j > 0; j--) seen[j] = seen[j-1];
      seen[0] = bh[1];
      rose = '0;
      for (int i = 0; i < N; i++) begin
        all_diff = 1;
        for (int j = 0; j < D; j++) if (seen[j][i] == m_db[i]) all_diff = 0;
        if (all_diff) begin
          rose[i] = ~m_db[i];
          m_db[i] = ~m_db[i];
        end
      end
      m_press = rose;
      bh[1] = bh[0];
      bh[0] = btn;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("score", score_trigger, m_score);
    chk("miss", miss_trigger, m_miss);
    if (m_score || m_miss) chk("hit_index", hit_index, m_idx);
    chk("exclusive", score_trigger & miss_trigger, 0);
    if (score_trigger) n_score++;
    if (miss_trigger) n_miss++;
    if (score_trigger || miss_trigger) last_idx = hit_index;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  int s, sm;
  int hold [N];
  bit found;

  initial begin
    rst = 1; enable = 0; btn = '0; mole_mask = '0;
    run(3);
    chk("rst_score", score_trigger, 0);
    chk("rst_miss", miss_trigger, 0);
    chk("rst_index", hit_index, 0);
    chk("rst_state", dut.state_q == IDLE, 1);
    rst = 0;

    // hit
    enable = 1; mole_mask = 9'b000010000; run(2);
    s = n_score; btn[4] = 1; run(10);
    chk("hit_count", n_score - s, 1);
    chk("hit_idx", last_idx, 4);
    btn = '0; run(10);

    // bounce then steady hold
    mole_mask = 9'b000000100; run(2);
    s = n_score;
    for (int t = 0; t < 10; t++) begin btn[2] = ~btn[2]; run(2); end
    chk("bounce_count", n_score - s, 0);
    btn[2] = 1; run(10);
    chk("bounce_hold_count", n_score - s, 1);
    chk("bounce_idx", last_idx, 2);
    btn = '0; run(10);

    // simultaneous press
    mole_mask = 9'b001000010; run(2);
    s = n_score; btn[1] = 1; btn[6] = 1; run(12);
    chk("simul_count", n_score - s, 1);
    chk("simul_idx", last_idx, 1);
    btn = '0; run(10);

    // lockout
    mole_mask = 9'b000001000; run(2);
    s = n_score; btn[3] = 1; run(10);
    chk("lock_first", n_score - s, 1);
    btn = '0; run(10);
    s = n_score; btn[3] = 1; run(10);
    chk("lock_repress", n_score - s, 0);
    btn = '0; run(10);
    mole_mask = '0; run(2);
    mole_mask = 9'b000001000; run(2);
    s = n_score; btn[3] = 1; run(10);
    chk("lock_rearm", n_score - s, 1);
    chk("lock_idx", last_idx, 3);
    btn = '0; run(10);

    // miss
    mole_mask = '0; run(2);
    s = n_score; sm = n_miss; btn[0] = 1; run(10);
    chk("miss_count", n_miss - sm, MISS_EN ? 1 : 0);
    chk("miss_no_score", n_score - s, 0);
    btn = '0; run(10);

    // reset mid-debounce
    mole_mask = 9'b000100000; run(2);
    s = n_score; btn[5] = 1; run(4);
    rst = 1; btn = '0; run(1);
    chk("rst_mid_state", dut.state_q == IDLE, 1);
    rst = 0; run(1);
    chk("rst_mid_after", score_trigger | miss_trigger, 0);
    run(10);
    chk("rst_mid_count", n_score - s, 0);

    // enable drops in the press-event cycle
    run(2);
    s = n_score; btn[5] = 1; found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (m_press[5]) found = 1;
    end
    chk("dis_press_seen", found, 1);
    enable = 0; run(1);
    chk("dis_state", dut.state_q == IDLE, 1);
    run(5);
    chk("dis_count", n_score - s, 0);
    btn = '0; run(10);
    enable = 1;

    // random
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn[i] = ~btn[i];
          hold[i] = $urandom_range(1, 14);
        end
      end
      if ($urandom_range(0, 19) == 0) mole_mask = N'($urandom);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    chk("random_activity", (n_score > 8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
